// File: rtl/sort_batch_ctrl_if.sv
// Serial pair stream into and out of the sort batch sequencer.
// The slave modport is the controller side and the master modport is the producer/consumer side.
interface sort_batch_ctrl_if #(
  parameter int PAIR_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [PAIR_W-1:0] in_pair;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [PAIR_W-1:0] out_pair;
  logic              out_last;

  modport slave (
    input  in_valid, in_pair, in_last, out_ready,
    output in_ready, out_valid, out_pair, out_last
  );

  modport master (
    output in_valid, in_pair, in_last, out_ready,
    input  in_ready, out_valid, out_pair, out_last
  );
endinterface

// File: rtl/sort_batch_ctrl.sv
// Packs a serial pair stream into padded 8-entry batches for sorter_8, buffers the sorted results
// and re-serialises them with the pads stripped. Issue credits keep the sorter from overrunning the buffer.
module sort_batch_ctrl #(
  parameter int PAIR_W      = 128,
  parameter bit ASC         = 1'b1,
  parameter int SORT_LAT    = 6,
  parameter int BUF_BATCHES = 2
) (
  input  logic                clock,
  input  logic                reset,
  sort_batch_ctrl_if.slave    stream,
  output logic                sort_valid_in,
  output logic [8*PAIR_W-1:0] sort_pairs_in,
  input  logic                sort_valid_out,
  input  logic [8*PAIR_W-1:0] sort_pairs_out,
  output logic                busy,
  output logic                err_overflow
);

  localparam int PTR_W = (BUF_BATCHES > 1) ? $clog2(BUF_BATCHES) : 1;
  localparam int CRD_W = $clog2(BUF_BATCHES + 1);
  localparam logic [PAIR_W-1:0] PAD = ASC ? {PAIR_W{1'b1}} : {PAIR_W{1'b0}};

  if (BUF_BATCHES < 1 || SORT_LAT < 1) begin : g_param_check
    $error("sort_batch_ctrl: BUF_BATCHES and SORT_LAT must both be at least 1");
  end

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state;
  logic [PAIR_W-1:0] slots [8];
  logic [2:0]        fill_cnt;
  logic [3:0]        cnt;
  logic              lst;
  logic [CRD_W-1:0]  credits;

  logic [3:0]        tag_cnt [BUF_BATCHES];
  logic              tag_lst [BUF_BATCHES];
  logic [PTR_W-1:0]  tag_wr;
  logic [CRD_W-1:0]  tag_count;

  logic [PAIR_W-1:0] buffer [BUF_BATCHES][8];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CRD_W-1:0]  buf_count;
  logic [2:0]        rd_idx;
  logic              err_q;

  logic       accept;
  logic       close_batch;
  logic       issue_fire;
  logic       out_avail;
  logic       beat;
  logic       at_batch_end;
  logic       credit_ret;
  logic       buf_full;
  logic       capture_ok;
  logic [3:0] head_cnt;
  logic       head_lst;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(BUF_BATCHES - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Tags and buffer entries share one read pointer because the sorter returns batches in issue order.
  always_comb begin
    head_cnt     = tag_cnt[rd_ptr];
    head_lst     = tag_lst[rd_ptr];
    out_avail    = (buf_count != '0);
    beat         = out_avail && stream.out_ready;
    at_batch_end = ({1'b0, rd_idx} == (head_cnt - 4'd1));
    credit_ret   = beat && at_batch_end;
    accept       = (state == FILL) && stream.in_valid;
    close_batch  = accept && (stream.in_last || (fill_cnt == 3'd7));
    issue_fire   = (state == ISSUE) && ((credits != '0) || credit_ret);
    buf_full     = (buf_count == CRD_W'(BUF_BATCHES));
    capture_ok   = sort_valid_out && !buf_full;
  end

  // Issue bus is zero except in the one cycle a batch is handed to the sorter.
  always_comb begin
    sort_pairs_in = '0;
    for (int i = 0; i < 8; i++) begin
      sort_pairs_in[i*PAIR_W +: PAIR_W] = issue_fire ? slots[i] : {PAIR_W{1'b0}};
    end
  end

  assign sort_valid_in    = issue_fire;
  assign stream.in_ready  = (state == FILL);
  assign stream.out_valid = out_avail;
  assign stream.out_pair  = out_avail ? buffer[rd_ptr][rd_idx] : {PAIR_W{1'b0}};
  assign stream.out_last  = out_avail && head_lst && at_batch_end;
  assign busy             = (state == ISSUE) || (fill_cnt != 3'd0) || (tag_count != '0);
  assign err_overflow     = err_q;

  // Input FSM: collect up to 8 pairs into the slots, then hold in ISSUE until a credit allows the hand-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FILL;
      fill_cnt <= 3'd0;
      cnt      <= 4'd0;
      lst      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        slots[i] <= PAD;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            slots[fill_cnt] <= stream.in_pair;
            fill_cnt        <= fill_cnt + 3'd1;
            if (close_batch) begin
              state <= ISSUE;
              cnt   <= {1'b0, fill_cnt} + 4'd1;
              lst   <= stream.in_last;
            end
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            for (int i = 0; i < 8; i++) begin
              slots[i] <= PAD;
            end
            fill_cnt <= 3'd0;
            state    <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  // Tag FIFO and credit counter; a simultaneous issue and credit return leave both counts unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      credits   <= CRD_W'(BUF_BATCHES);
      tag_wr    <= '0;
      tag_count <= '0;
    end else begin
      if (issue_fire) begin
        tag_cnt[tag_wr] <= cnt;
        tag_lst[tag_wr] <= lst;
        tag_wr          <= ptr_next(tag_wr);
      end
      case ({issue_fire, credit_ret})
        2'b10: begin
          credits   <= credits - CRD_W'(1);
          tag_count <= tag_count + CRD_W'(1);
        end
        2'b01: begin
          credits   <= credits + CRD_W'(1);
          tag_count <= tag_count - CRD_W'(1);
        end
        default: begin
          credits   <= credits;
          tag_count <= tag_count;
        end
      endcase
    end
  end

  // Result buffer: capture sorted batches, drain real entries only, flag any capture into a full buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      rd_idx    <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      if (capture_ok) begin
        for (int i = 0; i < 8; i++) begin
          buffer[wr_ptr][i] <= sort_pairs_out[i*PAIR_W +: PAIR_W];
        end
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (sort_valid_out && buf_full) begin
        err_q <= 1'b1;
      end
      if (beat) begin
        if (at_batch_end) begin
          rd_idx <= 3'd0;
          rd_ptr <= ptr_next(rd_ptr);
        end else begin
          rd_idx <= rd_idx + 3'd1;
        end
      end
      case ({capture_ok, credit_ret})
        2'b10:   buf_count <= buf_count + CRD_W'(1);
        2'b01:   buf_count <= buf_count - CRD_W'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule
